// File: rtl/hack_mem_system_pkg.sv
// Shared constants, loader state and address-decode helper for the Hack memory system.
// Imported by the loader sub-module and the top.
package hack_mem_pkg;

   localparam int ROM_AW_DEF = 15;
   localparam int RAM_AW_DEF = 14;
   localparam int SCR_AW_DEF = 13;

   localparam logic [15:0] SCREEN_BASE = 16'h4000;
   localparam logic [15:0] KBD_ADDR    = 16'h6000;

   typedef enum logic {LOAD, RUN} loader_state_e;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_SCR,
      REG_KBD,
      REG_NONE
   } mem_region_e;

   // Bit 15 of the CPU data address is not part of the map, so it is masked off first.
   function automatic mem_region_e decode_addr(input logic [15:0] addr);
      logic [15:0] a;
      mem_region_e region;
      a = addr & 16'h7FFF;
      if (a < SCREEN_BASE) begin
         region = REG_RAM;
      end else if (a < KBD_ADDR) begin
         region = REG_SCR;
      end else if (a == KBD_ADDR) begin
         region = REG_KBD;
      end else begin
         region = REG_NONE;
      end
      return region;
   endfunction

endpackage

// File: rtl/hack_mem_system_if.sv
// CPU-side memory bus plus host loader stream for the Hack memory system.
// master = CPU/host side, slave = memory system.
interface hack_mem_if;

   logic [15:0] pc;
   logic [15:0] instruction;
   logic [15:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;

   logic        ld_valid;
   logic        ld_ready;
   logic [15:0] ld_data;
   logic        ld_last;

   modport master (
      output pc, addressM, outM, writeM, ld_valid, ld_data, ld_last,
      input  instruction, inM, ld_ready
   );

   modport slave (
      input  pc, addressM, outM, writeM, ld_valid, ld_data, ld_last,
      output instruction, inM, ld_ready
   );

endinterface

// File: rtl/hack_mem_system_rom_loader.sv
// Instruction ROM with streaming loader; holds the CPU in reset until the program is in.
// Optional HACK_LOADER_CHECKSUM_EN adds a running 16-bit sum of accepted words.
module hack_rom_loader
   import hack_mem_pkg::*;
#(
   parameter int ROM_AW = ROM_AW_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic        ld_valid,
   input  logic [15:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic [15:0] instruction,
   output logic        cpu_reset,
   output logic        run,
   output logic [15:0] loaded_words
`ifdef HACK_LOADER_CHECKSUM_EN
   ,
   output logic [15:0] ld_checksum
`endif
);

   localparam int          ROM_WORDS = 1 << ROM_AW;
   localparam logic [15:0] LAST_IDX  = 16'(ROM_WORDS - 1);

   logic [15:0] rom_mem [ROM_WORDS];

   loader_state_e state_q, state_d;
   logic [15:0]   loaded_words_q, loaded_words_d;
   logic          accept;

   assign accept = ld_valid && (state_q == LOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= LOAD;
         loaded_words_q <= 16'h0000;
      end else begin
         state_q        <= state_d;
         loaded_words_q <= loaded_words_d;
      end
   end

   // Filling the last ROM slot ends the load even without ld_last.
   always_comb begin
      state_d        = state_q;
      loaded_words_d = loaded_words_q;
      if (accept) begin
         loaded_words_d = loaded_words_q + 16'd1;
         if (ld_last || (loaded_words_q == LAST_IDX)) begin
            state_d = RUN;
         end
      end
   end

   always_comb begin
      ld_ready     = (state_q == LOAD);
      cpu_reset    = (state_q == LOAD);
      run          = (state_q == RUN);
      loaded_words = loaded_words_q;
      instruction  = 16'h0000;
      if ((state_q == RUN) && (pc < loaded_words_q)) begin
         instruction = rom_mem[pc[ROM_AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !reset) begin
         rom_mem[loaded_words_q[ROM_AW-1:0]] <= ld_data;
      end
   end

`ifdef HACK_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (accept) begin
         checksum_d = checksum_q + ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_q <= 16'h0000;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign ld_checksum = checksum_q;
`endif

endmodule

// File: rtl/hack_mem_system.sv
// Hack memory system: ROM loader, data RAM, screen RAM with display read port, keyboard register.
// Define HACK_LOADER_CHECKSUM_EN to expose ld_checksum.
module hack_mem_system
   import hack_mem_pkg::*;
#(
   parameter int ROM_AW = ROM_AW_DEF,
   parameter int RAM_AW = RAM_AW_DEF,
   parameter int SCR_AW = SCR_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   hack_mem_if.slave         bus,
   input  logic [15:0]       kbd_code,
   input  logic [SCR_AW-1:0] scr_rd_addr,
   output logic [15:0]       scr_rd_data,
   output logic              cpu_reset,
   output logic [15:0]       loaded_words
`ifdef HACK_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       ld_checksum
`endif
);

   logic run;

   hack_rom_loader #(
      .ROM_AW (ROM_AW)
   ) u_loader (
      .clk          (clk),
      .reset        (reset),
      .pc           (bus.pc),
      .ld_valid     (bus.ld_valid),
      .ld_data      (bus.ld_data),
      .ld_last      (bus.ld_last),
      .ld_ready     (bus.ld_ready),
      .instruction  (bus.instruction),
      .cpu_reset    (cpu_reset),
      .run          (run),
      .loaded_words (loaded_words)
`ifdef HACK_LOADER_CHECKSUM_EN
      ,
      .ld_checksum  (ld_checksum)
`endif
   );

   logic [15:0] ram_mem [1 << RAM_AW];
   logic [15:0] scr_mem [1 << SCR_AW];

   logic [15:0] kbd_q, kbd_d;
   logic [15:0] scr_rd_data_q, scr_rd_data_d;
   mem_region_e region;
   logic        wr_en;

   assign region = decode_addr(bus.addressM);
   assign wr_en  = bus.writeM && run;

   always_comb begin
      bus.inM = 16'h0000;
      case (region)
         REG_RAM:  bus.inM = ram_mem[bus.addressM[RAM_AW-1:0]];
         REG_SCR:  bus.inM = scr_mem[bus.addressM[SCR_AW-1:0]];
         REG_KBD:  bus.inM = kbd_q;
         default:  bus.inM = 16'h0000;
      endcase
   end

   // Display read samples the array before this edge's write lands, so it sees old data.
   always_comb begin
      kbd_d         = kbd_code;
      scr_rd_data_d = scr_mem[scr_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         kbd_q         <= 16'h0000;
         scr_rd_data_q <= 16'h0000;
      end else begin
         kbd_q         <= kbd_d;
         scr_rd_data_q <= scr_rd_data_d;
      end
   end

   assign scr_rd_data = scr_rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en && (region == REG_RAM)) begin
         ram_mem[bus.addressM[RAM_AW-1:0]] <= bus.outM;
      end
      if (wr_en && (region == REG_SCR)) begin
         scr_mem[bus.addressM[SCR_AW-1:0]] <= bus.outM;
      end
   end

endmodule

// File: tb/tb_hack_mem_system.sv
// Self-checking bench for hack_mem_system: directed load/reset sequences, a vector table,
// and randomized CPU traffic checked against a plain-array memory map model.
module tb_hack_mem_system;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] kbd_code;
   logic [12:0] scr_rd_addr;
   logic [15:0] scr_rd_data;
   logic        cpu_reset;
   logic [15:0] loaded_words;
`ifdef HACK_LOADER_CHECKSUM_EN
   logic [15:0] ld_checksum;
   logic [15:0] sum_m;
`endif

   hack_mem_if bus ();

   hack_mem_system dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .kbd_code     (kbd_code),
      .scr_rd_addr  (scr_rd_addr),
      .scr_rd_data  (scr_rd_data),
      .cpu_reset    (cpu_reset),
      .loaded_words (loaded_words)
`ifdef HACK_LOADER_CHECKSUM_EN
      ,
      .ld_checksum  (ld_checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] ram_m [16384];
   logic [15:0] scr_m [8192];
   logic [15:0] kbd_m;
   logic [15:0] written [$];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        we;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory map model: mask bit 15, then RAM / screen / keyboard / nothing by plain ranges.
   function automatic logic [15:0] model_read(input logic [15:0] a);
      int ea;
      ea = int'(a) & 32'h7FFF;
      if (ea < 16384)       return ram_m[ea];
      else if (ea < 24576)  return scr_m[ea - 16384];
      else if (ea == 24576) return kbd_m;
      else                  return 16'h0000;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [15:0] d);
      int ea;
      ea = int'(a) & 32'h7FFF;
      if (ea < 16384) begin
         ram_m[ea] = d;
         written.push_back(16'(ea));
      end else if (ea < 24576) begin
         scr_m[ea - 16384] = d;
         written.push_back(16'(ea));
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      bus.addressM = a;
      bus.outM     = d;
      bus.writeM   = 1'b1;
      tick();
      bus.writeM   = 1'b0;
      model_write(a, d);
   endtask

   task automatic load_word(input logic [15:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      tick();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_m = sum_m + d;
`endif
   endtask

   task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
      bus.addressM = a;
      #1;
      check_output(name, bus.inM, exp);
   endtask

   task automatic fetch_check(input string name, input logic [15:0] p, input logic [15:0] exp);
      bus.pc = p;
      #1;
      check_output(name, bus.instruction, exp);
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      bus.addressM = v.addr;
      bus.outM     = v.data;
      bus.writeM   = v.we;
      tick();
      bus.writeM   = 1'b0;
      if (v.we) model_write(v.addr, v.data);
      #1;
      check_output($sformatf("table[%0d] inM@%h", idx, v.addr), bus.inM, v.exp);
   endtask

   initial begin
      logic [15:0] a, code, rom_sum;
      int op, ea;

      reset = 1'b1;
      kbd_code = 16'h1234;
      scr_rd_addr = '0;
      bus.pc = '0; bus.addressM = 16'h6000; bus.outM = '0; bus.writeM = 1'b0;
      bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
      kbd_m = 16'h0000;
      tick();
      tick();

      check_output("reset cpu_reset", {15'b0, cpu_reset}, 16'h0001);
      check_output("reset ld_ready", {15'b0, bus.ld_ready}, 16'h0001);
      check_output("reset loaded_words", loaded_words, 16'h0000);
      check_output("reset instruction", bus.instruction, 16'h0000);
      check_output("reset scr_rd_data", scr_rd_data, 16'h0000);
      check_output("reset kbd reg", bus.inM, 16'h0000);
`ifdef HACK_LOADER_CHECKSUM_EN
      check_output("reset checksum", ld_checksum, 16'h0000);
      sum_m = 16'h0000;
`endif
      kbd_code = 16'h0000;
      reset = 1'b0;
      tick();

      // First program load, with an idle gap between beats
      load_word(16'h000A, 1'b0);
      check_output("load1 loaded_words", loaded_words, 16'd1);
      check_output("load1 cpu_reset", {15'b0, cpu_reset}, 16'h0001);
      fetch_check("load1 instr in LOAD", 16'd0, 16'h0000);
      tick();
      check_output("idle loaded_words", loaded_words, 16'd1);
      load_word(16'hEC10, 1'b0);
      load_word(16'h000B, 1'b1);
      check_output("run ld_ready", {15'b0, bus.ld_ready}, 16'h0000);
      check_output("run cpu_reset", {15'b0, cpu_reset}, 16'h0000);
      check_output("run loaded_words", loaded_words, 16'd3);
      fetch_check("pc0", 16'd0, 16'h000A);
      fetch_check("pc1", 16'd1, 16'hEC10);
      fetch_check("pc2", 16'd2, 16'h000B);
      fetch_check("pc3 beyond", 16'd3, 16'h0000);
`ifdef HACK_LOADER_CHECKSUM_EN
      check_output("checksum 3 words", ld_checksum, 16'hEC25);
`endif
      bus.ld_valid = 1'b1; bus.ld_data = 16'h7777; bus.ld_last = 1'b1;
      tick();
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
      check_output("run beat ignored", loaded_words, 16'd3);
      fetch_check("pc2 after ignored beat", 16'd2, 16'h000B);

      // Keyboard register latency
      bus.addressM = 16'h6000;
      kbd_code = 16'h0041;
      #1;
      check_output("kbd before edge", bus.inM, 16'h0000);
      tick();
      kbd_m = 16'h0041;
      check_output("kbd after edge", bus.inM, 16'h0041);

      vecs.push_back('{16'd11,    16'd10,    1'b1, 16'd10});
      vecs.push_back('{16'h4005,  16'hFFFF,  1'b1, 16'hFFFF});
      vecs.push_back('{16'h6000,  16'h9999,  1'b1, 16'h0041});
      vecs.push_back('{16'h7000,  16'h5555,  1'b1, 16'h0000});
      vecs.push_back('{16'h800B,  16'h0000,  1'b0, 16'd10});
      vecs.push_back('{16'h3FFF,  16'hAAAA,  1'b1, 16'hAAAA});
      vecs.push_back('{16'h4000,  16'h1357,  1'b1, 16'h1357});
      vecs.push_back('{16'h5FFF,  16'h0F0F,  1'b1, 16'h0F0F});
      vecs.push_back('{16'h6001,  16'h7777,  1'b1, 16'h0000});
      vecs.push_back('{16'hC005,  16'h0000,  1'b0, 16'hFFFF});
      vecs.push_back('{16'h8000,  16'hBBBB,  1'b1, 16'hBBBB});
      vecs.push_back('{16'h0000,  16'h0000,  1'b0, 16'hBBBB});
      vecs.push_back('{16'hFFFF,  16'h3333,  1'b1, 16'h0000});
      for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);
      read_check("0x3FFF not aliased by 0x7FFF write", 16'h3FFF, 16'hAAAA);

      // Display port: registered read, old data on same-cycle write
      scr_rd_addr = 13'd5;
      tick();
      check_output("scr_rd 5", scr_rd_data, 16'hFFFF);
      cpu_write(16'h4005, 16'h2468);
      check_output("scr_rd old on collision", scr_rd_data, 16'hFFFF);
      tick();
      check_output("scr_rd new after collision", scr_rd_data, 16'h2468);

      // Randomized CPU traffic against the model
      for (int it = 0; it < 300; it++) begin
         op = int'($urandom_range(0, 4));
         case (op)
            0: begin
               a = 16'($urandom_range(12, 16'h3FFF));
               if ($urandom_range(0, 1) == 1) a[15] = 1'b1;
               cpu_write(a, 16'($urandom));
            end
            1: begin
               ea = int'($urandom_range(0, 8191));
               cpu_write(16'(16384 + ea), 16'($urandom));
               scr_rd_addr = 13'(ea);
               tick();
               check_output("rand scr_rd", scr_rd_data, scr_m[ea]);
            end
            2: begin
               if (written.size() > 0) begin
                  a = written[$urandom_range(0, written.size() - 1)];
                  if ($urandom_range(0, 1) == 1) a[15] = 1'b1;
                  read_check($sformatf("rand read %h", a), a, model_read(a));
               end
            end
            3: begin
               code = 16'($urandom);
               read_check("rand kbd old", 16'h6000, kbd_m);
               kbd_code = code;
               tick();
               kbd_m = code;
               read_check("rand kbd new", 16'h6000, model_read(16'h6000));
            end
            default: begin
               a = 16'h6001 + 16'($urandom_range(0, 16'h1FFE));
               if ($urandom_range(0, 1) == 1) a[15] = 1'b1;
               cpu_write(a, 16'($urandom));
               read_check("rand unmapped", a, 16'h0000);
            end
         endcase
      end

      // Reset while running, then reload with a CPU write attempted during LOAD
      cpu_write(16'h0000, 16'h1111);
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_m = 16'h0000;
      check_output("rerun checksum cleared", ld_checksum, 16'h0000);
`endif
      check_output("rerun cpu_reset", {15'b0, cpu_reset}, 16'h0001);
      check_output("rerun ld_ready", {15'b0, bus.ld_ready}, 16'h0001);
      check_output("rerun loaded_words", loaded_words, 16'h0000);
      fetch_check("rerun instr pc1", 16'd1, 16'h0000);
      read_check("RAM[11] kept", 16'd11, 16'd10);
      bus.addressM = 16'h0000;
      bus.outM     = 16'h2222;
      bus.writeM   = 1'b1;
      load_word(16'hFFFF, 1'b0);
      load_word(16'h0002, 1'b1);
      bus.writeM   = 1'b0;
      check_output("reload cpu_reset", {15'b0, cpu_reset}, 16'h0000);
      check_output("reload loaded_words", loaded_words, 16'd2);
      read_check("RAM[0] untouched by LOAD write", 16'h0000, 16'h1111);
      fetch_check("reload pc0", 16'd0, 16'hFFFF);
      fetch_check("reload pc1", 16'd1, 16'h0002);
      fetch_check("reload pc2 beyond", 16'd2, 16'h0000);
`ifdef HACK_LOADER_CHECKSUM_EN
      check_output("checksum wrap", ld_checksum, 16'h0001);
      bus.ld_valid = 1'b1; bus.ld_data = 16'h1234;
      tick();
      bus.ld_valid = 1'b0;
      check_output("checksum frozen in RUN", ld_checksum, 16'h0001);
`endif

      // Fill the whole ROM with ld_last never asserted
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rom_sum = 16'h0000;
      bus.ld_valid = 1'b1;
      bus.ld_last  = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         bus.ld_data = 16'(i) ^ 16'h5A5A;
         rom_sum = rom_sum + (16'(i) ^ 16'h5A5A);
         tick();
      end
      bus.ld_valid = 1'b0;
      check_output("full ld_ready", {15'b0, bus.ld_ready}, 16'h0000);
      check_output("full cpu_reset", {15'b0, cpu_reset}, 16'h0000);
      check_output("full loaded_words", loaded_words, 16'h8000);
      fetch_check("full pc0", 16'h0000, 16'h5A5A);
      fetch_check("full pc 0x1234", 16'h1234, 16'h1234 ^ 16'h5A5A);
      fetch_check("full pc 0x7FFF", 16'h7FFF, 16'h7FFF ^ 16'h5A5A);
      fetch_check("full pc 0x8000", 16'h8000, 16'h0000);
`ifdef HACK_LOADER_CHECKSUM_EN
      check_output("full checksum", ld_checksum, rom_sum);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
